// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes and default slave-side widths.
// Used by the terminator slave, the ROM slave and the interconnect.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int AXI4L_ADDR_SIZE = 10;
    localparam int AXI4L_DATA_SIZE = 32;

    function automatic int strb_width(input int data_size);
        return data_size / 8;
    endfunction

endpackage

// File: rtl/axi4l_decerr_slave.sv
// Default AXI4-Lite terminator: completes every read and write with DECERR so a
// master addressing an unmapped window always gets a response.
module axi4l_decerr_slave
    import axi4l_pkg::*;
#(
    parameter int                   ADDR_SIZE  = AXI4L_ADDR_SIZE,
    parameter int                   DATA_SIZE  = AXI4L_DATA_SIZE,
    parameter logic [DATA_SIZE-1:0] RDATA_FILL = '0
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [ADDR_SIZE-1:0]   awaddr,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DATA_SIZE-1:0]   wdata,
    input  logic [DATA_SIZE/8-1:0] wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [ADDR_SIZE-1:0]   araddr,
    input  logic [2:0]             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [DATA_SIZE-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready
);

    // Handshake rule on every channel: a transfer happens at a rising ACLK edge
    // where valid && ready; a raised valid and its payload stay put until then.

    logic aw_seen;
    logic w_seen;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic unused_inputs;

    // Address, protection, data and strobes never influence the response.
    assign unused_inputs = ^{awaddr, awprot, wdata, wstrb, araddr, arprot};

    assign awready = !aw_seen && !bvalid && ARESETn;
    assign wready  = !w_seen && !bvalid && ARESETn;
    assign arready = !rvalid && ARESETn;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // Join AW and W in any order; the response issues once both have landed.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_seen <= 1'b0;
            w_seen  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else if (bvalid) begin
            if (bready) begin
                bvalid <= 1'b0;
                bresp  <= OKAY;
            end
        end else if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
            aw_seen <= 1'b0;
            w_seen  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= DECERR;
        end else begin
            if (aw_hs) aw_seen <= 1'b1;
            if (w_hs)  w_seen  <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid <= 1'b0;
            rresp  <= OKAY;
            rdata  <= '0;
        end else if (rvalid) begin
            if (rready) begin
                rvalid <= 1'b0;
                rresp  <= OKAY;
                rdata  <= '0;
            end
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= DECERR;
            rdata  <= RDATA_FILL;
        end
    end

endmodule

// File: tb/tb_axi4l_decerr_slave.sv
// Bench for axi4l_decerr_slave: directed and random traffic, scoreboard model
// built from transaction counts and expected-response queues.
module tb_axi4l_decerr_slave;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam logic [DW-1:0] FILL = 32'h0000_0000;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    logic          ACLK;
    logic          ARESETn;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    axi4l_decerr_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // clock / reset
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: open writes counted per channel, responses queued with due cycle
    logic [1:0]    exp_b_q[$];
    int            b_due_q[$];
    logic [DW+1:0] exp_r_q[$];
    int            r_due_q[$];
    int            aw_pend = 0;
    int            w_pend = 0;
    bit            aw_hs_s, w_hs_s, ar_hs_s;

    task automatic model_flush();
        exp_b_q.delete();
        b_due_q.delete();
        exp_r_q.delete();
        r_due_q.delete();
        aw_pend = 0;
        w_pend = 0;
        aw_hs_s = 0;
        w_hs_s = 0;
        ar_hs_s = 0;
    endtask

    // monitor / scoreboard
    always @(negedge ACLK) begin
        if (mon_en && ARESETn) begin
            bit exp_bv, exp_rv;
            chk("awready", awready, (aw_pend == 0 && exp_b_q.size() == 0));
            chk("wready", wready, (w_pend == 0 && exp_b_q.size() == 0));
            chk("arready", arready, exp_r_q.size() == 0);
            exp_bv = exp_b_q.size() > 0 && b_due_q[0] <= cyc;
            exp_rv = exp_r_q.size() > 0 && r_due_q[0] <= cyc;
            chk("bvalid", bvalid, exp_bv);
            chk("bresp", bresp, exp_bv ? exp_b_q[0] : RESP_OKAY);
            chk("rvalid", rvalid, exp_rv);
            chk("rresp", rresp, exp_rv ? exp_r_q[0][DW+1:DW] : RESP_OKAY);
            chk("rdata", rdata, exp_rv ? exp_r_q[0][DW-1:0] : '0);
            if (exp_bv && bready) begin
                void'(exp_b_q.pop_front());
                void'(b_due_q.pop_front());
            end
            if (exp_rv && rready) begin
                void'(exp_r_q.pop_front());
                void'(r_due_q.pop_front());
            end
            aw_hs_s = awvalid && awready;
            w_hs_s  = wvalid && wready;
            ar_hs_s = arvalid && arready;
            if (aw_hs_s) aw_pend++;
            if (w_hs_s) w_pend++;
            if (aw_pend > 0 && w_pend > 0) begin
                aw_pend--;
                w_pend--;
                exp_b_q.push_back(RESP_DECERR);
                b_due_q.push_back(cyc + 1);
            end
            if (ar_hs_s) begin
                exp_r_q.push_back({RESP_DECERR, FILL});
                r_due_q.push_back(cyc + 1);
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic send_aw(input logic [AW-1:0] a);
        int k;
        awaddr = a;
        awprot = 3'($urandom_range(0, 7));
        awvalid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (awready) break;
        end
        if (k == 50) begin
            fails++;
            $display("FAIL aw_timeout: awready stuck 0 after 50 cycles");
        end
        step(1);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d);
        int k;
        wdata = d;
        wstrb = 4'($urandom);
        wvalid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (wready) break;
        end
        if (k == 50) begin
            fails++;
            $display("FAIL w_timeout: wready stuck 0 after 50 cycles");
        end
        step(1);
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        int k;
        araddr = a;
        arprot = 3'($urandom_range(0, 7));
        arvalid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (arready) break;
        end
        if (k == 50) begin
            fails++;
            $display("FAIL ar_timeout: arready stuck 0 after 50 cycles");
        end
        step(1);
        arvalid = 1'b0;
    endtask

    initial begin
        int k;
        ARESETn = 1'b0;
        awaddr = '0; awprot = '0; wdata = '0; wstrb = '0;
        araddr = '0; arprot = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0;
        model_flush();

        // reset with all valids high: nothing may be accepted or answered
        step(3);
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, '0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        ARESETn = 1'b1;
        #1;
        chk("rel_awready", awready, 1'b1);
        chk("rel_wready", wready, 1'b1);
        chk("rel_arready", arready, 1'b1);
        mon_en = 1;
        step(2);

        // same-cycle AW+W, master ready for the response
        bready = 1'b1;
        fork
            send_aw(10'h3FC);
            send_w(32'hDEAD_BEEF);
        join
        step(4);

        // W three cycles ahead of AW, response back-pressured for 4 cycles
        bready = 1'b0;
        send_w($urandom);
        step(2);
        send_aw($urandom);
        awaddr = 10'($urandom);
        awvalid = 1'b1;
        step(4);
        bready = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (awready) break;
        end
        step(1);
        awvalid = 1'b0;
        send_w($urandom);
        step(3);

        // read held off for two cycles by rready
        rready = 1'b0;
        send_ar(10'h004);
        step(2);
        rready = 1'b1;
        step(3);

        // concurrent read and write
        fork
            send_aw($urandom);
            send_w($urandom);
            send_ar($urandom);
        join
        step(3);

        // reset while both responses are pending
        bready = 1'b0;
        rready = 1'b0;
        fork
            send_aw($urandom);
            send_w($urandom);
            send_ar($urandom);
        join
        step(1);
        ARESETn = 1'b0;
        #1;
        chk("midrst_bvalid", bvalid, 1'b0);
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_bresp", bresp, 2'b00);
        chk("midrst_rresp", rresp, 2'b00);
        model_flush();
        step(2);
        bready = 1'b1;
        rready = 1'b1;
        ARESETn = 1'b1;
        step(6);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (awvalid && aw_hs_s) awvalid = 1'b0;
            if (wvalid && w_hs_s) wvalid = 1'b0;
            if (arvalid && ar_hs_s) arvalid = 1'b0;
            if (!awvalid && $urandom_range(0, 3) == 0) begin
                awvalid = 1'b1;
                awaddr = 10'($urandom);
                awprot = 3'($urandom);
            end
            if (!wvalid && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b1;
                wdata = $urandom;
                wstrb = 4'($urandom);
            end
            if (!arvalid && $urandom_range(0, 3) == 0) begin
                arvalid = 1'b1;
                araddr = 10'($urandom);
                arprot = 3'($urandom);
            end
            bready = 1'($urandom_range(0, 1));
            rready = 1'($urandom_range(0, 1));
        end

        // drain: finish open transfers, accept everything
        bready = 1'b1;
        rready = 1'b1;
        for (k = 0; k < 200; k++) begin
            step(1);
            if (awvalid && aw_hs_s) awvalid = 1'b0;
            if (wvalid && w_hs_s) wvalid = 1'b0;
            if (arvalid && ar_hs_s) arvalid = 1'b0;
            if (aw_pend > 0 && !wvalid) wvalid = 1'b1;
            if (w_pend > 0 && !awvalid) awvalid = 1'b1;
            if (!awvalid && !wvalid && !arvalid && aw_pend == 0 && w_pend == 0
                && exp_b_q.size() == 0 && exp_r_q.size() == 0) break;
        end
        if (k == 200) begin
            fails++;
            $display("FAIL drain_timeout: transactions still open after 200 cycles");
        end
        step(2);
        chk("final_b_outstanding", exp_b_q.size(), 0);
        chk("final_r_outstanding", exp_r_q.size(), 0);
        chk("final_bvalid", bvalid, 1'b0);
        chk("final_rvalid", rvalid, 1'b0);
        mon_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
